alu_seg_display_seq: RTL and testbench
======================================

Name: alu_seg_display_seq

Overview:
- Parametrised, registered ALU with a multi-cycle sequential divider and a time-multiplexed N-digit hex seven-segment display driver.
- Operands and opcode are captured on a START strobe. The result is held in a register until the next accepted operation.
- The display continuously scans either the held result or the operand pair.
- Sits between the board switch/button inputs and the seven-segment/anode pins.

Parameters:
- DATA_W, 4, operand width in bits (>=2); result width RES_W = 2*DATA_W.
- DIGITS, 4, number of display digits / anode lines (>=1).
- REFRESH_DIV, 100000, CLK cycles per digit slot (>=2).

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- A  in  DATA_W  operand A.
- B  in  DATA_W  operand B.
- OP  in  4  opcode.
- START  in  1  one-cycle request; sampled only when BUSY=0.
- DISP_SEL  in  1  0 = display RESULT; 1 = display {A,B}.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle pulse when RESULT/flags update.
- RESULT  out  RES_W  held result.
- FLG_UF  out  1  subtraction underflow (held).
- FLG_DZ  out  1  divide by zero (held).
- FLG_ILL  out  1  illegal opcode (held).
- SEG  out  7  active-low segments {g,f,e,d,c,b,a}.
- AN  out  DIGITS  active-low anodes; AN[0] = rightmost digit.

Behaviour:
- Reset (RST_N=0, asynchronous): RESULT=0, all flags 0, BUSY=0, DONE=0, refresh counter=0, digit index=0.
  - AN and SEG are driven from the reset state: AN = all ones except AN[0]=0; SEG shows digit 0 of the display word.
- FSM states: IDLE, DIV, FIN.
  - IDLE with START=1: latch A, B, OP.
    - OP = DIV or MOD -> go to DIV with BUSY=1.
    - Any other opcode -> compute the result, go to FIN.
  - FIN lasts one cycle: writes RESULT and all three flags, asserts DONE, returns to IDLE. Flags not relevant to the opcode are cleared.
  - START while BUSY=1 is ignored, not queued.
- Latency from the START cycle:
  - Single-cycle ops: DONE 2 cycles after START.
  - DIV/MOD: DIV state lasts DATA_W cycles (restoring, one quotient bit per cycle, MSB first), so DONE comes DATA_W+2 cycles after START.
- Opcodes:
  - 0 ADD: zero-extended sum.
  - 1 SUB: A-B; if A<B then RESULT=0 and FLG_UF=1.
  - 2 MUL: unsigned product, full RES_W bits.
  - 3 DIV: quotient, zero-extended.
  - 4 AND, 5 OR, 6 XOR: zero-extended.
  - 7 MOD: remainder, zero-extended.
  - 8-15: RESULT=0, FLG_ILL=1, single-cycle.
- Divide by zero (B=0 for DIV/MOD): skips the DIV state and goes straight to FIN. RESULT = all ones (RES_W bits), FLG_DZ=1.
- Reset during DIV aborts the operation: no DONE is generated and RESULT=0.
- Display word W is DIGITS*4 bits, taken as the low bits of the zero-extended source; wider sources are truncated.
  - DISP_SEL=0: source is RESULT.
  - DISP_SEL=1: source is {A,B} taken live from the inputs (not the latched copies).
- Refresh counter counts 0..REFRESH_DIV-1 and then wraps to 0. On the wrap cycle the digit index increments; it wraps from DIGITS-1 to 0.
- AN[i]=0 only for i = digit index. SEG shows W nibble [4i+3:4i].
- Hex encoding: 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000, A:0001000, b:0000011, C:1000110, d:0100001, E:0000110, F:0001110. Blank = 1111111.
- SEG/AN are combinational from the registered digit index and W. The display never stalls while BUSY=1.

Optional Feature:
- Macro: ALU_SEG_LEADING_ZERO_BLANK_EN.
- Defined: when DISP_SEL=0, digits above the most significant non-zero nibble of W show blank (1111111). Digit 0 is never blanked, so a zero value shows "0". DISP_SEL=1 is never blanked.
- Undefined: every digit shows its hex value, including leading zeros.

Decomposition:
- Package alu_seg_pkg holds:
  - Opcode constants/enum (OP_ADD..OP_MOD).
  - FSM state type.
  - Seven-segment hex encoding table and SEG_BLANK.
- Sub-module alu_seq_div: restoring divider with inputs start, dividend, divisor and outputs quotient, remainder, done. It has its own CLK/RST_N.
- Hex-to-segment decode is a package function, not a module.

Test Plan:
- DATA_W=4, A=7, B=3, OP=0, START pulse -> DONE 2 cycles later, RESULT=0x0A, all flags 0; with REFRESH_DIV=4, the AN[0] slot shows SEG=0001000.
- A=3, B=7, OP=1 -> RESULT=0x00, FLG_UF=1. Next op A=15, B=15, OP=2 -> RESULT=0xE1, FLG_UF=0.
- A=13, B=4, OP=3 -> BUSY high for 4 cycles, DONE at START+6, RESULT=0x03. Same operands with OP=7 -> RESULT=0x01. START pulsed mid-division is ignored.
- A=9, B=0, OP=3 -> RESULT=0xFF, FLG_DZ=1, DONE at START+2. OP=12 -> RESULT=0, FLG_ILL=1.
- REFRESH_DIV=4, DIGITS=4 -> AN sequence 1110, 1101, 1011, 0111, each held 4 cycles, then wraps. DISP_SEL=1 with A=5, B=C -> digits 0/1 show C/5 and digits 2/3 show 0.
- RST_N asserted during the DIV state -> BUSY=0 and RESULT=0 immediately, no DONE afterwards. With ALU_SEG_LEADING_ZERO_BLANK_EN and RESULT=0x05, digits 1-3 are blank.

Source files
------------

// File: rtl/alu_seg_pkg.sv
// alu_seg_pkg: opcodes, FSM states and seven-segment encoding shared by alu_seg_display_seq.
package alu_seg_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
      OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_MOD = 4'd7
   } op_e;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_e;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Active-low {g,f,e,d,c,b,a}, indexed by nibble value
   localparam logic [6:0] SEG_HEX [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
      return SEG_HEX[n];
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return op == OP_DIV || op == OP_MOD;
   endfunction

endpackage

// File: rtl/alu_seq_div.sv
// alu_seq_div: restoring divider, one quotient bit per cycle MSB first; done flags the final step.
module alu_seq_div
   import alu_seg_pkg::*;
#(
   parameter int W = 4
)(
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         done
);

   localparam int CNT_W = $clog2(W + 1);

   logic [W-1:0]     dvs;
   logic [CNT_W-1:0] cnt;
   logic [W:0]       shifted;
   logic             ge;

   assign shifted = {remainder, quotient[W-1]};
   assign ge      = shifted >= {1'b0, dvs};
   assign done    = cnt == CNT_W'(1);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         quotient  <= '0;
         remainder <= '0;
         dvs       <= '0;
         cnt       <= '0;
      end else if (start) begin
         quotient  <= dividend;
         remainder <= '0;
         dvs       <= divisor;
         cnt       <= CNT_W'(W);
      end else if (cnt != '0) begin
         quotient  <= {quotient[W-2:0], ge};
         remainder <= ge ? W'(shifted - {1'b0, dvs}) : W'(shifted);
         cnt       <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/alu_seg_display_seq.sv
// alu_seg_display_seq: registered ALU with sequential divider and multiplexed hex display.
// Define ALU_SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits when showing RESULT.
module alu_seg_display_seq
   import alu_seg_pkg::*;
#(
   parameter int DATA_W      = 4,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000
)(
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [DATA_W-1:0]   A,
   input  logic [DATA_W-1:0]   B,
   input  logic [3:0]          OP,
   input  logic                START,
   input  logic                DISP_SEL,
   output logic                BUSY,
   output logic                DONE,
   output logic [2*DATA_W-1:0] RESULT,
   output logic                FLG_UF,
   output logic                FLG_DZ,
   output logic                FLG_ILL,
   output logic [6:0]          SEG,
   output logic [DIGITS-1:0]   AN
);

   localparam int RES_W = 2 * DATA_W;
   localparam int CW    = $clog2(REFRESH_DIV);
   localparam int DW    = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int WW    = 4 * DIGITS;
   localparam int NW    = 4 * (2 ** DW);

   state_e            state;
   logic [DATA_W-1:0] a_q, b_q, quo, rem;
   logic [3:0]        op_q;
   logic              div_go, div_start, div_done;
   logic [RES_W-1:0]  fin_res;
   logic              fin_uf, fin_dz, fin_ill;
   logic [CW-1:0]     ref_cnt;
   logic [DW-1:0]     dig;
   logic [NW-1:0]     w_pad;
   logic [3:0]        nib;
   logic              blank;

   assign div_go    = is_div_op(OP) && B != '0;
   assign div_start = state == S_IDLE && START && div_go;

   alu_seq_div #(.W(DATA_W)) u_div (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .start     (div_start),
      .dividend  (A),
      .divisor   (B),
      .quotient  (quo),
      .remainder (rem),
      .done      (div_done)
   );

   always_comb begin
      fin_res = '0;
      fin_uf  = 1'b0;
      fin_dz  = 1'b0;
      fin_ill = 1'b0;
      case (op_q)
         OP_ADD: fin_res = RES_W'(a_q) + RES_W'(b_q);
         OP_SUB: begin
            fin_uf  = a_q < b_q;
            fin_res = fin_uf ? '0 : RES_W'(a_q - b_q);
         end
         OP_MUL: fin_res = RES_W'(a_q) * RES_W'(b_q);
         OP_DIV, OP_MOD: begin
            fin_dz  = b_q == '0;
            fin_res = fin_dz ? '1 : RES_W'(op_q == OP_DIV ? quo : rem);
         end
         OP_AND: fin_res = RES_W'(a_q & b_q);
         OP_OR:  fin_res = RES_W'(a_q | b_q);
         OP_XOR: fin_res = RES_W'(a_q ^ b_q);
         default: fin_ill = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         RESULT  <= '0;
         FLG_UF  <= 1'b0;
         FLG_DZ  <= 1'b0;
         FLG_ILL <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            S_IDLE: if (START) begin
               a_q   <= A;
               b_q   <= B;
               op_q  <= OP;
               BUSY  <= div_go;
               state <= div_go ? S_DIV : S_FIN;
            end
            S_DIV: if (div_done) begin
               BUSY  <= 1'b0;
               state <= S_FIN;
            end
            S_FIN: begin
               RESULT  <= fin_res;
               FLG_UF  <= fin_uf;
               FLG_DZ  <= fin_dz;
               FLG_ILL <= fin_ill;
               DONE    <= 1'b1;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ref_cnt <= '0;
         dig     <= '0;
      end else begin
         ref_cnt <= ref_cnt == CW'(REFRESH_DIV - 1) ? '0 : ref_cnt + 1'b1;
         if (ref_cnt == CW'(REFRESH_DIV - 1))
            dig <= dig == DW'(DIGITS - 1) ? '0 : dig + 1'b1;
      end
   end

   // Display word truncated/extended to DIGITS nibbles, then padded so any index is in range
   assign w_pad = NW'(WW'(DISP_SEL ? {A, B} : RESULT));
   assign nib   = w_pad[{dig, 2'b00} +: 4];

`ifdef ALU_SEG_LEADING_ZERO_BLANK_EN
   assign blank = !DISP_SEL && dig != '0 && (w_pad >> {dig, 2'b00}) == '0;
`else
   assign blank = 1'b0;
`endif

   assign SEG = blank ? SEG_BLANK : hex_to_seg(nib);
   assign AN  = ~(DIGITS'(1) << dig);

endmodule

// File: tb/tb_alu_seg_display_seq.sv
// tb_alu_seg_display_seq: randomized and directed checks of the ALU, divider timing and display scan.
module tb_alu_seg_display_seq;

   localparam int DATA_W = 4, DIGITS = 4, REFRESH_DIV = 4, RES_W = 8;

   logic             CLK = 0, RST_N = 0, START = 0, DISP_SEL = 0;
   logic [3:0]       A = 0, B = 0, OP = 0;
   logic             BUSY, DONE, FLG_UF, FLG_DZ, FLG_ILL;
   logic [RES_W-1:0] RESULT;
   logic [6:0]       SEG;
   logic [3:0]       AN;

   int tests = 0, fails = 0, ticks = 0;
   logic [RES_W-1:0] exp_res = '0;

   localparam logic [6:0] HEX [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef struct packed {
      logic [3:0] a, b, op;
      logic [7:0] r;
      logic       uf, dz, ill;
      logic [7:0] lat;
   } vec_t;

   alu_seg_display_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) dut (
      .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .OP(OP), .START(START), .DISP_SEL(DISP_SEL),
      .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .FLG_UF(FLG_UF), .FLG_DZ(FLG_DZ),
      .FLG_ILL(FLG_ILL), .SEG(SEG), .AN(AN)
   );

   always #5 CLK = ~CLK;

   // Clock edges since reset release; the digit slot follows from plain division
   always @(posedge CLK or negedge RST_N)
      if (!RST_N) ticks <= 0;
      else ticks <= ticks + 1;

   function automatic void model(input int a, b, op, output logic [RES_W-1:0] r,
                                 output logic uf, dz, ill, output int lat);
      r = '0; uf = 0; dz = 0; ill = 0; lat = 2;
      if (op > 7) ill = 1;
      else if (op == 1) begin
         uf = a < b;
         r = uf ? '0 : RES_W'(a - b);
      end else if (op == 3 || op == 7) begin
         if (b == 0) begin
            dz = 1;
            r = '1;
         end else begin
            r = RES_W'(op == 3 ? a / b : a % b);
            lat = DATA_W + 2;
         end
      end else
         r = RES_W'(op == 0 ? a + b : op == 2 ? a * b : op == 4 ? a & b : op == 5 ? a | b : a ^ b);
   endfunction

   function automatic logic [6:0] exp_seg(input int d, input logic sel, input logic [RES_W-1:0] res,
                                          input logic [3:0] a, b);
      logic [15:0] w;
      int nib;
      w = sel ? {8'h00, a, b} : 16'(res);
`ifdef ALU_SEG_LEADING_ZERO_BLANK_EN
      if (!sel && d != 0 && (w >> (4 * d)) == 16'h0) return 7'b1111111;
`endif
      nib = int'((w >> (4 * d)) & 16'hF);
      return HEX[nib];
   endfunction

   task automatic do_op(input logic [3:0] a, b, op, output int lat, output int busy_n);
      @(negedge CLK);
      A = a; B = b; OP = op; START = 1;
      lat = 0; busy_n = 0;
      do begin
         @(negedge CLK);
         lat++;
         START = 0;
         if (BUSY === 1'b1) busy_n++;
      end while (DONE !== 1'b1 && lat < 30);
      if (DONE !== 1'b1) lat = -1;
   endtask

   task automatic check_display(input int n, input string name);
      int d;
      logic [3:0] ea;
      logic [6:0] es;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         d = (ticks / REFRESH_DIV) % DIGITS;
         ea = ~(4'b0001 << d);
         es = exp_seg(d, DISP_SEL, exp_res, A, B);
         tests++;
         if (AN !== ea) begin
            fails++;
            $display("FAIL %s an: got %b expected %b", name, AN, ea);
         end
         tests++;
         if (SEG !== es) begin
            fails++;
            $display("FAIL %s seg digit %0d: got %b expected %b", name, d, SEG, es);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge CLK);
      tests++;
      if ({RESULT, FLG_UF, FLG_DZ, FLG_ILL, BUSY, DONE} !== '0) begin
         fails++;
         $display("FAIL reset_regs: got res=%h uf=%b dz=%b ill=%b busy=%b done=%b expected all 0",
                  RESULT, FLG_UF, FLG_DZ, FLG_ILL, BUSY, DONE);
      end
      tests++;
      if (AN !== 4'b1110 || SEG !== 7'b1000000) begin
         fails++;
         $display("FAIL reset_display: got an=%b seg=%b expected 1110 1000000", AN, SEG);
      end
      RST_N = 1;
      check_display(20, "reset_scan");
   endtask

   task automatic test_directed();
      vec_t v;
      int lat, busy_n;
      vec_t vecs [15] = '{
         '{4'd7,  4'd3,  4'd0,  8'h0A, 1'b0, 1'b0, 1'b0, 8'd2},
         '{4'd3,  4'd7,  4'd1,  8'h00, 1'b1, 1'b0, 1'b0, 8'd2},
         '{4'd15, 4'd15, 4'd2,  8'hE1, 1'b0, 1'b0, 1'b0, 8'd2},
         '{4'd13, 4'd4,  4'd3,  8'h03, 1'b0, 1'b0, 1'b0, 8'd6},
         '{4'd13, 4'd4,  4'd7,  8'h01, 1'b0, 1'b0, 1'b0, 8'd6},
         '{4'd9,  4'd0,  4'd3,  8'hFF, 1'b0, 1'b1, 1'b0, 8'd2},
         '{4'd9,  4'd0,  4'd7,  8'hFF, 1'b0, 1'b1, 1'b0, 8'd2},
         '{4'd9,  4'd5,  4'd12, 8'h00, 1'b0, 1'b0, 1'b1, 8'd2},
         '{4'd10, 4'd12, 4'd4,  8'h08, 1'b0, 1'b0, 1'b0, 8'd2},
         '{4'd10, 4'd12, 4'd5,  8'h0E, 1'b0, 1'b0, 1'b0, 8'd2},
         '{4'd10, 4'd12, 4'd6,  8'h06, 1'b0, 1'b0, 1'b0, 8'd2},
         '{4'd6,  4'd6,  4'd1,  8'h00, 1'b0, 1'b0, 1'b0, 8'd2},
         '{4'd15, 4'd1,  4'd3,  8'h0F, 1'b0, 1'b0, 1'b0, 8'd6},
         '{4'd15, 4'd15, 4'd0,  8'h1E, 1'b0, 1'b0, 1'b0, 8'd2},
         '{4'd7,  4'd3,  4'd0,  8'h0A, 1'b0, 1'b0, 1'b0, 8'd2}
      };
      for (int i = 0; i < 15; i++) begin
         v = vecs[i];
         do_op(v.a, v.b, v.op, lat, busy_n);
         tests++;
         if (lat !== int'(v.lat)) begin
            fails++;
            $display("FAIL dir%0d latency: got %0d expected %0d", i, lat, v.lat);
         end
         tests++;
         if ({RESULT, FLG_UF, FLG_DZ, FLG_ILL} !== {v.r, v.uf, v.dz, v.ill}) begin
            fails++;
            $display("FAIL dir%0d result: got %h uf=%b dz=%b ill=%b expected %h uf=%b dz=%b ill=%b",
                     i, RESULT, FLG_UF, FLG_DZ, FLG_ILL, v.r, v.uf, v.dz, v.ill);
         end
         tests++;
         if (busy_n !== (v.lat == 8'd6 ? 4 : 0)) begin
            fails++;
            $display("FAIL dir%0d busy_cycles: got %0d expected %0d", i, busy_n, v.lat == 8'd6 ? 4 : 0);
         end
         exp_res = v.r;
         check_display(i == 14 ? 16 : 2, "dir_display");
      end
   endtask

   task automatic test_random();
      logic [3:0] a, b, op;
      logic [RES_W-1:0] r;
      logic uf, dz, ill;
      int lat, elat, busy_n;
      for (int i = 0; i < 40; i++) begin
         a = 4'($urandom_range(0, 15));
         b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
         model(int'(a), int'(b), int'(op), r, uf, dz, ill, elat);
         do_op(a, b, op, lat, busy_n);
         tests++;
         if ({RESULT, FLG_UF, FLG_DZ, FLG_ILL} !== {r, uf, dz, ill}) begin
            fails++;
            $display("FAIL rand_result a=%0d b=%0d op=%0d: got %h %b%b%b expected %h %b%b%b",
                     a, b, op, RESULT, FLG_UF, FLG_DZ, FLG_ILL, r, uf, dz, ill);
         end
         tests++;
         if (lat !== elat || busy_n !== (elat == 2 ? 0 : DATA_W)) begin
            fails++;
            $display("FAIL rand_timing op=%0d b=%0d: got lat=%0d busy=%0d expected lat=%0d", op, b, lat, busy_n, elat);
         end
         exp_res = r;
         @(negedge CLK);
         tests++;
         if (DONE !== 1'b0) begin
            fails++;
            $display("FAIL rand_done_pulse: got %b expected 0", DONE);
         end
         DISP_SEL = 1'($urandom_range(0, 1));
         check_display(2, "rand_display");
         DISP_SEL = 0;
      end
   endtask

   task automatic test_start_ignored();
      int lat;
      bit extra;
      @(negedge CLK);
      A = 13; B = 4; OP = 3; START = 1;
      @(negedge CLK);
      START = 0;
      @(negedge CLK);
      A = 15; B = 1; OP = 0; START = 1;
      @(negedge CLK);
      START = 0;
      lat = 3;
      while (DONE !== 1'b1 && lat < 30) begin
         @(negedge CLK);
         lat++;
      end
      tests++;
      if (lat !== 6 || RESULT !== 8'h03) begin
         fails++;
         $display("FAIL start_ignored: got lat=%0d res=%h expected lat=6 res=03", lat, RESULT);
      end
      exp_res = 8'h03;
      extra = 0;
      repeat (10) begin
         @(negedge CLK);
         if (DONE === 1'b1) extra = 1;
      end
      tests++;
      if (extra) begin
         fails++;
         $display("FAIL start_queued: got a second DONE expected none");
      end
   endtask

   task automatic test_reset_during_div();
      int lat, busy_n;
      bit seen;
      do_op(4'd7, 4'd3, 4'd0, lat, busy_n);
      exp_res = 8'h0A;
      @(negedge CLK);
      A = 13; B = 4; OP = 7; START = 1;
      @(negedge CLK);
      START = 0;
      @(negedge CLK);
      tests++;
      if (BUSY !== 1'b1) begin
         fails++;
         $display("FAIL div_busy: got %b expected 1", BUSY);
      end
      RST_N = 0;
      #1;
      tests++;
      if (BUSY !== 1'b0 || RESULT !== 8'h00 || DONE !== 1'b0) begin
         fails++;
         $display("FAIL reset_abort: got busy=%b res=%h done=%b expected 0 00 0", BUSY, RESULT, DONE);
      end
      exp_res = '0;
      @(negedge CLK);
      RST_N = 1;
      seen = 0;
      repeat (12) begin
         @(negedge CLK);
         if (DONE === 1'b1 || BUSY === 1'b1) seen = 1;
      end
      tests++;
      if (seen) begin
         fails++;
         $display("FAIL reset_no_done: got DONE/BUSY after abort expected none");
      end
      check_display(4, "post_abort");
   endtask

   task automatic test_display_scan();
      int lat, busy_n;
      DISP_SEL = 1; A = 5; B = 12;
      check_display(20, "operand_scan");
      DISP_SEL = 0;
      do_op(4'd5, 4'd7, 4'd4, lat, busy_n);
      tests++;
      if (RESULT !== 8'h05) begin
         fails++;
         $display("FAIL and_result: got %h expected 05", RESULT);
      end
      exp_res = 8'h05;
      check_display(20, "result_scan");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_reset_during_div();
      test_display_scan();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
